// File: rtl/pkt_input_arbiter.sv
// Two-port packet input arbiter. It grants one input port at a time, forwards
// that port's words to the header parser one cycle after acceptance, and keeps
// packets whole. Round-robin fairness is kept by remembering the last port served.
module pkt_input_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  in0_req,
  input  logic [DATA_WIDTH-1:0] in0_data,
  input  logic [CTRL_WIDTH-1:0] in0_ctrl,
  input  logic                  in0_wr,
  output logic                  in0_rdy,
  input  logic                  in1_req,
  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic [CTRL_WIDTH-1:0] in1_ctrl,
  input  logic                  in1_wr,
  output logic                  in1_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [1:0]            o_grant,
  output logic [CNT_WIDTH-1:0]  pkt_count0,
  output logic [CNT_WIDTH-1:0]  pkt_count1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [1:0]            grant_reg, grant_next;
  logic                  last_served_reg, last_served_next;
  logic                  out_wr_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [CTRL_WIDTH-1:0] out_ctrl_reg;
  logic [CNT_WIDTH-1:0]  cnt_reg [2];

  logic [1:0]            req_vec;
  logic [1:0]            wr_vec;
  logic [1:0]            rdy_vec;
  logic                  accept;
  logic                  eop;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [CTRL_WIDTH-1:0] sel_ctrl;

  assign req_vec = {in1_req, in0_req};
  assign wr_vec  = {in1_wr, in0_wr};

  // Only the owner sees ready, and only while downstream can take a word.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign rdy_vec[gi] = grant_reg[gi] & out_rdy;

      // Per-port packet counter, wraps naturally at all-ones.
      always_ff @(posedge i_clock) begin
        if (i_reset) begin
          cnt_reg[gi] <= '0;
        end else if (eop && grant_reg[gi]) begin
          cnt_reg[gi] <= cnt_reg[gi] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
      end
    end
  endgenerate

  assign in0_rdy    = rdy_vec[0];
  assign in1_rdy    = rdy_vec[1];
  assign accept     = |(rdy_vec & wr_vec);
  assign sel_data   = grant_reg[1] ? in1_data : in0_data;
  assign sel_ctrl   = grant_reg[1] ? in1_ctrl : in0_ctrl;
  assign o_grant    = grant_reg;
  assign out_wr     = out_wr_reg;
  assign out_data   = out_data_reg;
  assign out_ctrl   = out_ctrl_reg;
  assign pkt_count0 = cnt_reg[0];
  assign pkt_count1 = cnt_reg[1];

  // Arbitration state, owner and round-robin pointer.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg       <= IDLE;
      grant_reg       <= 2'b00;
      last_served_reg <= 1'b1;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      last_served_reg <= last_served_next;
    end
  end

  // Next-state: grant in IDLE, leave header on first ctrl==0 word,
  // close the packet on the first ctrl!=0 word in the body.
  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    last_served_next = last_served_reg;
    eop              = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          state_next = HDR;
          if (&req_vec) begin
            grant_next = last_served_reg ? 2'b01 : 2'b10;
          end else begin
            grant_next = req_vec;
          end
        end
      end
      HDR: begin
        if (accept && (sel_ctrl == '0)) begin
          state_next = BODY;
        end
      end
      BODY: begin
        if (accept && (sel_ctrl != '0)) begin
          eop              = 1'b1;
          state_next       = IDLE;
          grant_next       = 2'b00;
          last_served_next = grant_reg[1];
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 2'b00;
      end
    endcase
  end

  // Registered output stage: one cycle after acceptance, data held otherwise.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      out_wr_reg   <= 1'b0;
      out_data_reg <= '0;
      out_ctrl_reg <= '0;
    end else begin
      out_wr_reg <= accept;
      if (accept) begin
        out_data_reg <= sel_data;
        out_ctrl_reg <= sel_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_pkt_input_arbiter.sv
// Randomized bench for pkt_input_arbiter. Each port is a queue of complete
// packets; a packet-level reference model decides ownership and predicts the
// forwarded word stream, grants and packet counts every cycle.
module tb_pkt_input_arbiter;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int NW = 3;

  typedef logic [CW+DW-1:0] word_t;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          in0_req, in0_wr, in0_rdy;
  logic [DW-1:0] in0_data;
  logic [CW-1:0] in0_ctrl;
  logic          in1_req, in1_wr, in1_rdy;
  logic [DW-1:0] in1_data;
  logic [CW-1:0] in1_ctrl;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          out_wr, out_rdy;
  logic [1:0]    o_grant;
  logic [NW-1:0] pkt_count0, pkt_count1;

  always #5 clk = ~clk;

  pkt_input_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .i_clock(clk), .i_reset(i_reset),
    .in0_req(in0_req), .in0_data(in0_data), .in0_ctrl(in0_ctrl), .in0_wr(in0_wr), .in0_rdy(in0_rdy),
    .in1_req(in1_req), .in1_data(in1_data), .in1_ctrl(in1_ctrl), .in1_wr(in1_wr), .in1_rdy(in1_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .o_grant(o_grant), .pkt_count0(pkt_count0), .pkt_count1(pkt_count1)
  );

  // Source queues (complete packets only) and reference model state.
  word_t         q0[$], q1[$];
  int            m_owner;
  bit            m_body;
  int            m_nbody;
  int            m_last;
  logic [NW-1:0] m_cnt0, m_cnt1;
  bit            e_wr;
  logic [DW-1:0] e_data;
  logic [CW-1:0] e_ctrl;

  int  chk_cnt  = 0;
  int  pass_cnt = 0;
  bit  ordy_rand = 0;
  int  ordy_low  = 0;
  bit  junk1     = 0;
  bit  do_rst    = 0;
  int  grant_log[$];
  logic [1:0] prev_grant = 2'b00;
  int  out_words = 0;

  function automatic void add_pkt(int port, int nbody);
    word_t w[$];
    int nh = $urandom_range(1, 2);
    for (int i = 0; i < nh; i++) w.push_back({8'($urandom_range(1, 255)), $urandom, $urandom});
    for (int i = 0; i < nbody; i++) w.push_back({8'h00, $urandom, $urandom});
    w.push_back({8'($urandom_range(1, 255)), $urandom, $urandom});
    foreach (w[i]) begin
      if (port == 0) q0.push_back(w[i]);
      else q1.push_back(w[i]);
    end
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_body = 0; m_nbody = 0; m_last = 1;
    m_cnt0 = '0; m_cnt1 = '0;
    e_wr = 0; e_data = '0; e_ctrl = '0;
  endfunction

  // One clock: check outputs against the model, drive inputs, check ready,
  // then advance the model across the coming edge.
  task automatic cycle();
    logic [1:0] exp_grant;
    bit acc;
    word_t w;
    @(negedge clk);
    exp_grant = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    chk_cnt++;
    if (o_grant !== exp_grant) $display("FAIL grant: got %b want %b at %0t", o_grant, exp_grant, $time);
    else pass_cnt++;
    chk_cnt++;
    if (out_wr !== e_wr) $display("FAIL out_wr: got %b want %b at %0t", out_wr, e_wr, $time);
    else pass_cnt++;
    chk_cnt++;
    if ({out_ctrl, out_data} !== {e_ctrl, e_data})
      $display("FAIL out_word: got %h/%h want %h/%h at %0t", out_ctrl, out_data, e_ctrl, e_data, $time);
    else pass_cnt++;
    chk_cnt++;
    if ({pkt_count1, pkt_count0} !== {m_cnt1, m_cnt0})
      $display("FAIL pkt_count: got %0d/%0d want %0d/%0d at %0t", pkt_count0, pkt_count1, m_cnt0, m_cnt1, $time);
    else pass_cnt++;
    if (out_wr === 1'b1) begin
      out_words++;
      $display("word %h/%h owner %b at %0t", out_ctrl, out_data, o_grant, $time);
    end
    if (o_grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(o_grant[1] ? 1 : 0);
    prev_grant = o_grant;

    i_reset = do_rst;
    do_rst  = 0;
    in0_req = (q0.size() > 0);
    in0_wr  = (q0.size() > 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
    if (q0.size() > 0) {in0_ctrl, in0_data} = q0[0];
    else {in0_ctrl, in0_data} = {8'($urandom), $urandom, $urandom};
    in1_req = (q1.size() > 0);
    in1_wr  = (q1.size() > 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
    if (q1.size() > 0) {in1_ctrl, in1_data} = q1[0];
    else if (junk1) begin in1_wr = 1'b1; in1_data = 64'hDEAD; in1_ctrl = 8'h00; end
    else {in1_ctrl, in1_data} = {8'($urandom), $urandom, $urandom};
    if (ordy_low > 0) begin out_rdy = 1'b0; ordy_low--; end
    else out_rdy = ordy_rand ? ($urandom_range(0, 4) != 0) : 1'b1;
    #1;
    chk_cnt++;
    if ({in1_rdy, in0_rdy} !== {(m_owner == 1) && out_rdy, (m_owner == 0) && out_rdy})
      $display("FAIL rdy: got %b%b owner %0d out_rdy %b at %0t", in1_rdy, in0_rdy, m_owner, out_rdy, $time);
    else pass_cnt++;

    if (i_reset) begin
      model_reset();
    end else begin
      e_wr = 0;
      if (m_owner < 0) begin
        if (in0_req && in1_req) m_owner = 1 - m_last;
        else if (in0_req) m_owner = 0;
        else if (in1_req) m_owner = 1;
        m_body = 0; m_nbody = 0;
      end else begin
        acc = ((m_owner == 0) ? in0_wr : in1_wr) && out_rdy;
        if (acc) begin
          w = (m_owner == 0) ? q0.pop_front() : q1.pop_front();
          e_wr = 1;
          {e_ctrl, e_data} = w;
          if (e_ctrl == '0) m_nbody++;
          if (!m_body) begin
            if (e_ctrl == '0) m_body = 1;
          end else if (e_ctrl != '0) begin
            if (m_owner == 0) m_cnt0++;
            else m_cnt1++;
            m_last = m_owner;
            m_owner = -1;
          end
        end
      end
    end
  endtask

  task automatic run_until_idle(int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_owner >= 0) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) begin
      chk_cnt++;
      $display("FAIL timeout: got %0d cycles want < %0d", n, budget);
    end
    cycle();
    cycle();
  endtask

  task automatic apply_reset();
    q0.delete(); q1.delete();
    do_rst = 1;
    cycle();
  endtask

  task automatic test_reset();
    i_reset = 1'b1; out_rdy = 1'b1;
    in0_req = 0; in0_wr = 0; in0_data = '0; in0_ctrl = '0;
    in1_req = 0; in1_wr = 0; in1_data = '0; in1_ctrl = '0;
    repeat (2) @(negedge clk);
    model_reset();
    chk_cnt++;
    if ({o_grant, out_wr, out_data, out_ctrl} !== '0)
      $display("FAIL reset_out: got %b %b %h %h want all zero", o_grant, out_wr, out_data, out_ctrl);
    else pass_cnt++;
    chk_cnt++;
    if ({pkt_count0, pkt_count1, in0_rdy, in1_rdy} !== '0)
      $display("FAIL reset_cnt: got %0d %0d rdy %b%b want 0 0 00", pkt_count0, pkt_count1, in1_rdy, in0_rdy);
    else pass_cnt++;
    i_reset = 1'b0;
    cycle();
  endtask

  task automatic test_single_packet();
    q0.push_back({8'hFF, 64'h1111_0000_0000_0001});
    q0.push_back({8'h00, 64'h2222_0000_0000_0002});
    q0.push_back({8'h00, 64'h3333_0000_0000_0003});
    q0.push_back({8'h00, 64'h4444_0000_0000_0004});
    q0.push_back({8'h08, 64'h5555_0000_0000_0005});
    out_words = 0;
    run_until_idle(200);
    chk_cnt++;
    if (out_words !== 5) $display("FAIL single_words: got %0d want 5", out_words);
    else pass_cnt++;
    chk_cnt++;
    if (pkt_count0 !== 3'd1 || o_grant !== 2'b00)
      $display("FAIL single_done: got cnt %0d grant %b want 1 00", pkt_count0, o_grant);
    else pass_cnt++;
  endtask

  task automatic test_alternation();
    int exp_order[6] = '{0, 1, 0, 1, 0, 1};
    apply_reset();
    grant_log.delete();
    for (int i = 0; i < 3; i++) begin
      add_pkt(0, $urandom_range(1, 3));
      add_pkt(1, $urandom_range(1, 3));
    end
    run_until_idle(1000);
    chk_cnt++;
    if (grant_log.size() != 6) $display("FAIL alt_count: got %0d grants want 6", grant_log.size());
    else pass_cnt++;
    for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
      chk_cnt++;
      if (grant_log[i] !== exp_order[i]) $display("FAIL alt_order[%0d]: got %0d want %0d", i, grant_log[i], exp_order[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (pkt_count0 !== 3'd3 || pkt_count1 !== 3'd3)
      $display("FAIL alt_cnt: got %0d/%0d want 3/3", pkt_count0, pkt_count1);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int n = 0;
    int len;
    apply_reset();
    add_pkt(0, 5);
    len = q0.size();
    out_words = 0;
    while (!(m_owner == 0 && m_body) && n < 100) begin cycle(); n++; end
    chk_cnt++;
    if (n >= 100) $display("FAIL stall_reach_body: got timeout want BODY");
    else pass_cnt++;
    ordy_low = 4;
    run_until_idle(300);
    chk_cnt++;
    if (out_words !== len) $display("FAIL stall_words: got %0d want %0d", out_words, len);
    else pass_cnt++;
  endtask

  task automatic test_nonowner();
    apply_reset();
    add_pkt(0, 3);
    junk1 = 1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      chk_cnt++;
      if (out_data === 64'hDEAD || in1_rdy !== 1'b0)
        $display("FAIL nonowner: got data %h in1_rdy %b want no DEAD, rdy 0", out_data, in1_rdy);
      else pass_cnt++;
    end
    junk1 = 0;
    run_until_idle(200);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    apply_reset();
    add_pkt(1, 3);
    while (!(m_owner == 1 && m_nbody == 2) && n < 200) begin cycle(); n++; end
    chk_cnt++;
    if (n >= 200) $display("FAIL rst_mid_reach: got timeout want 2 body words");
    else pass_cnt++;
    q1.delete();
    do_rst = 1;
    cycle();
    cycle();
    chk_cnt++;
    if (out_wr !== 1'b0 || o_grant !== 2'b00 || pkt_count1 !== '0)
      $display("FAIL rst_mid: got wr %b grant %b cnt1 %0d want 0 00 0", out_wr, o_grant, pkt_count1);
    else pass_cnt++;
    grant_log.delete();
    add_pkt(0, 1);
    add_pkt(1, 1);
    run_until_idle(300);
    chk_cnt++;
    if (grant_log.size() == 0 || grant_log[0] !== 0)
      $display("FAIL rst_mid_first: got %0d grants first %0d want port 0", grant_log.size(),
               (grant_log.size() > 0) ? grant_log[0] : -1);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < (1 << NW); i++) add_pkt(0, $urandom_range(1, 2));
    run_until_idle(2000);
    chk_cnt++;
    if (pkt_count0 !== '0) $display("FAIL wrap: got %0d want 0", pkt_count0);
    else pass_cnt++;
  endtask

  task automatic test_random();
    apply_reset();
    ordy_rand = 1;
    for (int i = 0; i < 24; i++) begin
      add_pkt($urandom_range(0, 1), $urandom_range(1, 4));
      repeat ($urandom_range(0, 12)) cycle();
    end
    run_until_idle(4000);
    ordy_rand = 0;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_alternation();
    test_stall();
    test_nonowner();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pkt_input_arbiter.md
PKT_INPUT_ARBITER -- requirements
Module: pkt_input_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the data word width.
REQ-002 Parameter CTRL_WIDTH, default DATA_WIDTH/8, SHALL set the ctrl width.
REQ-003 Parameter CNT_WIDTH, default 16, SHALL set the per-port packet counter width.
REQ-004 i_clock  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-005 i_reset  input  1  SHALL be the synchronous, active-high reset.
REQ-006 inN_req  input  1 (N=0,1)  SHALL indicate port N holds at least one complete packet.
REQ-007 inN_data  input  DATA_WIDTH  SHALL carry port N data.
REQ-008 inN_ctrl  input  CTRL_WIDTH  SHALL carry port N ctrl.
REQ-009 inN_wr  input  1  SHALL qualify the port N word.
REQ-010 inN_rdy  output  1  SHALL allow port N to present a word.
REQ-011 out_data / out_ctrl  output  DATA_WIDTH / CTRL_WIDTH  SHALL carry the forwarded word to the header parser.
REQ-012 out_wr  output  1  SHALL qualify out_data/out_ctrl.
REQ-013 out_rdy  input  1  SHALL be downstream ready; almost-full semantics: one word after deassertion is tolerated.
REQ-014 o_grant  output  2  SHALL be one-hot owner (bit N = port N); 2'b00 when idle.
REQ-015 pkt_countN  output  CNT_WIDTH (N=0,1)  SHALL count packets forwarded from port N.

Function
REQ-016 FSM states SHALL be IDLE, HDR, BODY.
REQ-017 IDLE: exactly one requester SHALL be granted; grant and move to HDR on the next edge.
REQ-018 IDLE, both requesting: the port not equal to last_served SHALL be granted; last_served resets to 1, so port 0 wins first.
REQ-019 IDLE, no request: stay in IDLE, o_grant=2'b00, both inN_rdy=0.
REQ-020 inN_rdy SHALL equal o_grant[N] AND out_rdy (combinational); non-granted port rdy=0.
REQ-021 Accepted word = granted inN_wr while inN_rdy=1; it SHALL appear on out_* with out_wr=1 exactly one cycle later (registered).
REQ-022 When no word is accepted, out_wr SHALL be 0 next cycle; out_data/out_ctrl SHALL hold their last value.
REQ-023 HDR: accepted word with ctrl==0 SHALL move the FSM to BODY; ctrl!=0 words stay in HDR.
REQ-024 BODY: accepted word with ctrl!=0 is end-of-packet; FSM SHALL return to IDLE, set last_served to the owner, and increment pkt_countN by 1.
REQ-025 A new grant SHALL not occur in the same cycle as end-of-packet; at least one IDLE cycle separates packets.
REQ-026 Words from the non-owner port SHALL never reach out_*; a packet SHALL never be interleaved.
REQ-027 inN_wr on a non-granted port SHALL be ignored.
REQ-028 inN_req changes during a packet SHALL not affect the current owner.
REQ-029 pkt_countN SHALL wrap from all-ones to 0 without saturating.
REQ-030 out_rdy low SHALL stall acceptance; FSM state and grant SHALL hold during the stall.

Reset
REQ-031 On i_reset: FSM=IDLE, o_grant=0, out_wr=0, out_data=0, out_ctrl=0, pkt_count0=pkt_count1=0, last_served=1, both inN_rdy=0.
REQ-032 Reset mid-packet SHALL abandon the packet: no end-of-packet count, no further out_wr until a new grant.
REQ-033 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-034 Port 0 only, 1 header (ctrl=FF), 3 data (ctrl=00), last (ctrl=08) -> 5 out_wr words identical and in order, each 1 cycle after acceptance; pkt_count0=1; o_grant back to 00.
REQ-035 Both req from reset, 3 packets each -> owner order 0,1,0,1,0,1; no interleaving; pkt_count0=pkt_count1=3.
REQ-036 out_rdy low for 4 cycles in BODY -> in0_rdy=0, out_wr=0 from the cycle after, no words lost or duplicated; packet completes after out_rdy returns.
REQ-037 in1_wr pulsed with data 0xDEAD while port 0 owns -> 0xDEAD never appears on out_data; in1_rdy stays 0.
REQ-038 i_reset asserted after 2 body words of port 1 -> next cycle out_wr=0, o_grant=00, counts=0; the next packet from port 0 is granted first.
REQ-039 Force pkt_count0 to all-ones -> 1 more packet -> pkt_count0=0.
